// File: rtl/lvds_video_packer_pkg.sv
// lvds_video_pkg: shared constants, FSM state and control bundle
// for the LVDS video packer.
package lvds_video_pkg;

  localparam logic MAP_VESA  = 1'b0;
  localparam logic MAP_JEIDA = 1'b1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
    24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000
  };

  function automatic int lanes_f(input int bpc);
    return (bpc == 8) ? 4 : 3;
  endfunction

endpackage

// File: rtl/lvds_video_packer_if.sv
// lvds_video_packer_if: pixel request / return bus between the
// packer (master) and the frame buffer (slave).
interface lvds_video_packer_if #(
  parameter int BPC = 8
);
  logic             pix_req;
  logic             pix_vld;
  logic [3*BPC-1:0] pix_data;

  modport master (
    output pix_req,
    input  pix_vld,
    input  pix_data
  );

  modport slave (
    input  pix_req,
    output pix_vld,
    output pix_data
  );
endinterface

// File: rtl/lvds_video_packer_lane_mapper.sv
// lvds_lane_mapper: combinational RGB + syncs -> LVDS lane bits.
// Lanes are written first-shifted-bit (bit 6) leftmost.
module lvds_lane_mapper
  import lvds_video_pkg::*;
#(
  parameter int BPC = 8
) (
  input  logic                      [3*BPC-1:0] rgb,
  input  logic                                  hs,
  input  logic                                  vs,
  input  logic                                  de,
  input  logic                                  map_sel,
  output logic [7*lanes_f(BPC)-1:0]             tx
);

  logic [BPC-1:0] r, g, b;
  logic [5:0]     rs, gs, bs;
  logic [6:0]     l0, l1, l2;

  assign {r, g, b} = rgb;

  assign l0 = {rs[0], rs[1], rs[2], rs[3], rs[4], rs[5], gs[0]};
  assign l1 = {gs[1], gs[2], gs[3], gs[4], gs[5], bs[0], bs[1]};
  assign l2 = {bs[2], bs[3], bs[4], bs[5], hs, vs, de};

  if (BPC == 8) begin : g_bpc8
    logic       jeida;
    logic [6:0] l3;
    assign jeida = map_sel == MAP_JEIDA;
    // JEIDA puts the top six bits on lanes 0-2, the two LSBs on lane3
    assign rs = jeida ? r[7:2] : r[5:0];
    assign gs = jeida ? g[7:2] : g[5:0];
    assign bs = jeida ? b[7:2] : b[5:0];
    assign l3 = jeida
      ? {r[0], r[1], g[0], g[1], b[0], b[1], 1'b0}
      : {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
    assign tx = {l3, l2, l1, l0};
  end else begin : g_bpc6
    logic unused_map;
    assign unused_map = map_sel;
    assign rs = r[5:0];
    assign gs = g[5:0];
    assign bs = b[5:0];
    assign tx = {l2, l1, l0};
  end

endmodule

// File: rtl/lvds_video_packer.sv
// lvds_video_packer: video timing, pixel fetch re-timing, LVDS packing.
// Define LVDS_VIDEO_PACKER_PATTERN_EN for the internal colour-bar source.
module lvds_video_packer
  import lvds_video_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 160,
  parameter int H_SYNC   = 20,
  parameter int H_BP     = 140,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 12,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 20,
  parameter int BPC      = 8,
  parameter int PIX_LAT  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic                         tx_sclk,
  input  logic                         rstn_final_tmp,
  input  logic                         enable,
  input  logic                         map_sel,
`ifdef LVDS_VIDEO_PACKER_PATTERN_EN
  input  logic                         pattern_sel,
`endif
  lvds_video_packer_if.master          pix,
  output logic                         h_valid,
  output logic                         v_valid,
  output logic                         de,
  output logic                         frame_start,
  output logic [7*lanes_f(BPC)-1:0]    tx_out,
  output logic                         underflow,
  input  logic                         underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int TXW     = 7 * lanes_f(BPC);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);
  localparam logic [2:0] SYNC_IDLE = {~HS_ON, ~VS_ON, 1'b0};
  // lane2 bits 2..0 = {HS, VS, DE}
  localparam logic [TXW-1:0] TX_BLANK = TXW'(SYNC_IDLE) << 14;

  logic [1:0]       rst_sync;
  logic             rst_n;
  state_t           state, state_nxt;
  logic [HW-1:0]    hcnt;
  logic [VW-1:0]    vcnt;
  logic             h_act, v_act, h_end, v_end, frame_end;
  logic             hs_win, vs_win, run, map_q;
  ctl_t             ctl_now, ctl_l;
  ctl_t [PIX_LAT-1:0] ctl_d;
  logic [3*BPC-1:0] src, rgb;
  logic             src_vld, miss, hs_lvl, vs_lvl;
  logic [TXW-1:0]   tx_nxt;

  always_ff @(posedge tx_sclk or negedge rstn_final_tmp) begin
    if (!rstn_final_tmp) rst_sync <= '0;
    else                 rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign h_act     = hcnt < HW'(H_ACTIVE);
  assign v_act     = vcnt < VW'(V_ACTIVE);
  assign h_end     = hcnt == HW'(H_TOTAL - 1);
  assign v_end     = vcnt == VW'(V_TOTAL - 1);
  assign frame_end = h_end && v_end;
  assign hs_win    = hcnt >= HW'(H_ACTIVE + H_FP) &&
                     hcnt <  HW'(H_ACTIVE + H_FP + H_SYNC);
  assign vs_win    = vcnt >= VW'(V_ACTIVE + V_FP) &&
                     vcnt <  VW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge tx_sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN:  if (frame_end && !enable) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run     = 1'b0;
    ctl_now = '0;
    unique case (state)
      IDLE: run = 1'b0;
      RUN: begin
        run        = 1'b1;
        ctl_now.de = h_act && v_act;
        ctl_now.hs = hs_win;
        ctl_now.vs = vs_win;
        ctl_now.fs = hcnt == '0 && vcnt == '0;
      end
    endcase
  end

  assign pix.pix_req = ctl_now.de;

  always_ff @(posedge tx_sclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_end) begin
      hcnt <= '0;
      vcnt <= v_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge tx_sclk or negedge rst_n) begin
    if (!rst_n)
      map_q <= MAP_VESA;
    else if ((!run && enable) || (run && frame_end))
      map_q <= map_sel;
  end

  always_ff @(posedge tx_sclk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_d <= '0;
    end else begin
      ctl_d[0] <= ctl_now;
      for (int i = 1; i < PIX_LAT; i++) ctl_d[i] <= ctl_d[i-1];
    end
  end
  assign ctl_l = ctl_d[PIX_LAT-1];

`ifdef LVDS_VIDEO_PACKER_PATTERN_EN
  logic [2:0]  bar_now;
  logic [2:0]  bar_d [PIX_LAT];
  logic [23:0] bar_rgb;

  assign bar_now = 3'((32'(hcnt) * 8) / H_ACTIVE);

  always_ff @(posedge tx_sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIX_LAT; i++) bar_d[i] <= '0;
    end else begin
      bar_d[0] <= bar_now;
      for (int i = 1; i < PIX_LAT; i++) bar_d[i] <= bar_d[i-1];
    end
  end

  assign bar_rgb = BAR_RGB[bar_d[PIX_LAT-1]];
  assign src     = pattern_sel
    ? {bar_rgb[23-:BPC], bar_rgb[15-:BPC], bar_rgb[7-:BPC]}
    : pix.pix_data;
  assign src_vld = pattern_sel || pix.pix_vld;
`else
  assign src     = pix.pix_data;
  assign src_vld = pix.pix_vld;
`endif

  // a missing pixel goes out black; blanking is forced to zero
  assign miss   = ctl_l.de && !src_vld;
  assign rgb    = (ctl_l.de && src_vld) ? src : '0;
  assign hs_lvl = ctl_l.hs ? HS_ON : ~HS_ON;
  assign vs_lvl = ctl_l.vs ? VS_ON : ~VS_ON;

  lvds_lane_mapper #(
    .BPC(BPC)
  ) u_map (
    .rgb     (rgb),
    .hs      (hs_lvl),
    .vs      (vs_lvl),
    .de      (ctl_l.de),
    .map_sel (map_q),
    .tx      (tx_nxt)
  );

  always_ff @(posedge tx_sclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_out      <= TX_BLANK;
      de          <= 1'b0;
      frame_start <= 1'b0;
      h_valid     <= 1'b0;
      v_valid     <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      tx_out      <= tx_nxt;
      de          <= ctl_l.de;
      frame_start <= ctl_l.fs;
      h_valid     <= run && h_act;
      v_valid     <= run && v_act;
      if (miss)               underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lvds_video_packer.sv
// tb_lvds_video_packer: random pixel/enable/map stimulus with a
// frame-position reference model feeding an output scoreboard.
module tb_lvds_video_packer;

  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam logic [27:0] BLANK = 28'h0018000;

  logic        tx_sclk = 1'b0;
  logic        rstn_final_tmp;
  logic        enable, map_sel, underflow_clr;
  logic        h_valid, v_valid, de, frame_start, underflow;
  logic [27:0] tx_out;

  lvds_video_packer_if #(.BPC(8)) pix_if ();

  lvds_video_packer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .BPC(8), .PIX_LAT(LAT), .HS_POL(0), .VS_POL(0)
  ) dut (
    .tx_sclk        (tx_sclk),
    .rstn_final_tmp (rstn_final_tmp),
    .enable         (enable),
    .map_sel        (map_sel),
`ifdef LVDS_VIDEO_PACKER_PATTERN_EN
    .pattern_sel    (1'b0),
`endif
    .pix            (pix_if),
    .h_valid        (h_valid),
    .v_valid        (v_valid),
    .de             (de),
    .frame_start    (frame_start),
    .tx_out         (tx_out),
    .underflow      (underflow),
    .underflow_clr  (underflow_clr)
  );

  always #5 tx_sclk = ~tx_sclk;

  typedef struct {
    logic [27:0] tx;
    logic        de;
    logic        fs;
    logic        uf;
  } exp_t;

  exp_t        expq[$];
  logic [24:0] fbq[$];
  bit          clrq[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          mon_on = 1'b0;

  bit m_run, m_map, m_uf, fixed_px;
  int m_h, m_v;

  // lanes listed first-shifted bit leftmost; syncs are active-low here
  function automatic logic [27:0] lvds_map(input logic [23:0] px,
      input bit hs_a, input bit vs_a, input bit de_b, input bit jeida);
    logic [7:0] r, g, b;
    logic [6:0] ln [4];
    int s, t;
    {r, g, b} = px;
    s = jeida ? 2 : 0;
    t = jeida ? 0 : 6;
    ln[0] = {r[s], r[s+1], r[s+2], r[s+3], r[s+4], r[s+5], g[s]};
    ln[1] = {g[s+1], g[s+2], g[s+3], g[s+4], g[s+5], b[s], b[s+1]};
    ln[2] = {b[s+2], b[s+3], b[s+4], b[s+5], !hs_a, !vs_a, de_b};
    ln[3] = {r[t], r[t+1], g[t], g[t+1], b[t], b[t+1], 1'b0};
    return {ln[3], ln[2], ln[1], ln[0]};
  endfunction

  task automatic chk(input string nm, input logic [27:0] got,
                     input logic [27:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic step(input bit en, input bit msel,
                      input bit drops, input bit clrs);
    bit req, hs_a, vs_a, fs, vld, clr;
    logic [23:0] px;
    logic [24:0] fb;
    exp_t e;
    enable  = en;
    map_sel = msel;
    req  = m_run && m_h < HA && m_v < VA;
    hs_a = m_run && m_h >= HA + HF && m_h < HA + HF + HSY;
    vs_a = m_run && m_v >= VA + VF && m_v < VA + VF + VSY;
    fs   = req && m_h == 0 && m_v == 0;
    n_vec++;
    if (pix_if.pix_req !== req) begin
      n_bad++;
      $display("FAIL pix_req h=%0d v=%0d got %b want %b",
               m_h, m_v, pix_if.pix_req, req);
    end
    px  = fixed_px ? 24'h814224 : 24'($urandom);
    vld = req && !(drops && $urandom_range(0, 7) == 0);
    if (!req) px = '0;
    fbq.push_back({vld, px});
    fb = fbq.pop_front();
    pix_if.pix_vld  = fb[24];
    pix_if.pix_data = fb[23:0];
    clr = clrs && $urandom_range(0, 5) == 0;
    clrq.push_back(clr);
    underflow_clr = clrq.pop_front();
    if (req && !vld) m_uf = 1'b1;
    else if (clr)    m_uf = 1'b0;
    e.tx = lvds_map(vld ? px : 24'h0, hs_a, vs_a, req, m_map);
    e.de = req;
    e.fs = fs;
    e.uf = m_uf;
    expq.push_back(e);
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_map = msel;
      end
    end else begin
      if (m_h == HT - 1 && m_v == VT - 1) begin
        m_map = msel;
        if (!en) m_run = 1'b0;
      end
      m_h = (m_h + 1) % HT;
      if (m_h == 0) m_v = (m_v + 1) % VT;
    end
    @(negedge tx_sclk);
  endtask

  always @(posedge tx_sclk) begin
    if (mon_on) begin
      #2;
      n_vec++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        mon_e = expq.pop_front();
        if (tx_out !== mon_e.tx || de !== mon_e.de ||
            frame_start !== mon_e.fs || underflow !== mon_e.uf) begin
          n_bad++;
          $display("FAIL out t=%0t tx=%h/%h de=%b/%b fs=%b/%b uf=%b/%b",
                   $time, tx_out, mon_e.tx, de, mon_e.de,
                   frame_start, mon_e.fs, underflow, mon_e.uf);
        end
      end
    end
  end

  initial begin
    rstn_final_tmp  = 1'b0;
    enable          = 1'b0;
    map_sel         = 1'b0;
    underflow_clr   = 1'b0;
    pix_if.pix_vld  = 1'b0;
    pix_if.pix_data = '0;
    m_run = 1'b0; m_map = 1'b0; m_uf = 1'b0; fixed_px = 1'b0;
    m_h = 0; m_v = 0;
    repeat (3) @(negedge tx_sclk);
    chk("rst_tx", tx_out, BLANK);
    chk("rst_de", 28'(de), '0);
    chk("rst_fs", 28'(frame_start), '0);
    chk("rst_uf", 28'(underflow), '0);
    chk("rst_hv", 28'({h_valid, v_valid}), '0);
    chk("rst_req", 28'(pix_if.pix_req), '0);

    rstn_final_tmp = 1'b1;
    for (int i = 0; i < LAT + 1; i++)
      expq.push_back('{BLANK, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < LAT; i++) begin
      fbq.push_back('0);
      clrq.push_back(1'b0);
    end
    mon_on = 1'b1;
    @(negedge tx_sclk);

    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
    fixed_px = 1'b1;
    repeat (HT * VT) step(1'b1, 1'b0, 1'b0, 1'b0);
    fixed_px = 1'b0;
    repeat (HT * VT) step(1'b1, 1'b0, 1'b0, 1'b0);
    fixed_px = 1'b1;
    repeat (HT * VT) step(1'b1, 1'b1, 1'b0, 1'b0);
    fixed_px = 1'b0;
    repeat (3 * HT * VT) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    repeat (3 * HT * VT) step(1'b1, 1'($urandom), 1'b1, 1'b1);
    repeat (3 * HT * VT)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b1, 1'b1);
    repeat (HT * VT + HT * 3 + 5) step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2 * HT * VT) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (HT * 2 + 5) step(1'b1, 1'b0, 1'b1, 1'b0);

    mon_on = 1'b0;
    rstn_final_tmp = 1'b0;
    #1;
    chk("arst_tx", tx_out, BLANK);
    chk("arst_de", 28'(de), '0);
    chk("arst_fs", 28'(frame_start), '0);
    chk("arst_uf", 28'(underflow), '0);
    chk("arst_hv", 28'({h_valid, v_valid}), '0);
    chk("arst_req", 28'(pix_if.pix_req), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
